// File: rtl/gate_seq_ctrl.sv
// gate_seq_ctrl: walks a 2-input gate cell through all four input vectors.
// Define GATE_SEQ_FAIL_CAPTURE_EN to add first-mismatch capture ports.
module gate_seq_ctrl #(
    parameter int unsigned SETTLE = 2,
    parameter logic [3:0]  TRUTH  = 4'b1110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       dut_a,
    output logic       dut_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    ,
    output logic       fail_valid,
    output logic [1:0] fail_vec
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_C = SETTLE[3:0];

    state_t     state_q;
    logic [1:0] vec_q;
    logic [3:0] cnt_q;
    logic       a_q;
    logic       b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [2:0] err_q;
    logic       mism_d;
    logic [2:0] err_d;

`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    logic       fval_q;
    logic [1:0] fvec_q;
    assign fail_valid = fval_q;
    assign fail_vec   = fvec_q;
`endif

    assign mism_d = (dut_out != TRUTH[vec_q]);
    assign err_d  = err_q + {2'b00, mism_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
            fval_q  <= 1'b0;
            fvec_q  <= 2'd0;
`endif
        end else begin
            done_q <= 1'b0;
            // abort outranks every transition, but only once a run is live
            if (state_q != S_IDLE && abort) begin
                state_q <= S_IDLE;
                a_q     <= 1'b0;
                b_q     <= 1'b0;
                busy_q  <= 1'b0;
                pass_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q <= S_APPLY;
                            vec_q   <= 2'd0;
                            a_q     <= 1'b0;
                            b_q     <= 1'b0;
                            busy_q  <= 1'b1;
                            pass_q  <= 1'b0;
                            err_q   <= 3'd0;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
                            fval_q  <= 1'b0;
                            fvec_q  <= 2'd0;
`endif
                        end
                    end
                    S_APPLY: begin
                        if (SETTLE_C == 4'd0) begin
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= SETTLE_C;
                        end
                    end
                    S_WAIT: begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        err_q <= err_d;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
                        if (mism_d && !fval_q) begin
                            fval_q <= 1'b1;
                            fvec_q <= vec_q;
                        end
`endif
                        if (vec_q == 2'd3) begin
                            state_q <= S_DONE;
                            a_q     <= 1'b0;
                            b_q     <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == 3'd0);
                        end else begin
                            state_q <= S_APPLY;
                            vec_q   <= vec_q + 2'd1;
                            {a_q, b_q} <= vec_q + 2'd1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dut_a   = a_q;
    assign dut_b   = b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Directed bench for gate_seq_ctrl: OR cell, settle 0/2/15, abort, reset,
// held start; fail-capture ports checked when GATE_SEQ_FAIL_CAPTURE_EN is set.
module tb_gate_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic stuck0 = 1'b0;

    logic a2, b2, busy2, done2, pass2, out2;
    logic [2:0] err2;
    logic a0, b0, busy0, done0, pass0, out0;
    logic [2:0] err0;
    logic a15, b15, busy15, done15, pass15, out15;
    logic [2:0] err15;
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
    logic fv2, fv0, fv15;
    logic [1:0] fvec2, fvec0, fvec15;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign out2  = stuck0 ? 1'b0 : (a2 | b2);
    assign out0  = a0 | b0;
    assign out15 = a15 | b15;

    gate_seq_ctrl #(.SETTLE(2), .TRUTH(4'b1110)) u2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_out(out2), .dut_a(a2), .dut_b(b2), .busy(busy2),
        .done(done2), .pass(pass2), .err_cnt(err2)
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
        , .fail_valid(fv2), .fail_vec(fvec2)
`endif
    );

    gate_seq_ctrl #(.SETTLE(0), .TRUTH(4'b1110)) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_out(out0), .dut_a(a0), .dut_b(b0), .busy(busy0),
        .done(done0), .pass(pass0), .err_cnt(err0)
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
        , .fail_valid(fv0), .fail_vec(fvec0)
`endif
    );

    gate_seq_ctrl #(.SETTLE(15), .TRUTH(4'b1110)) u15 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_out(out15), .dut_a(a15), .dut_b(b15), .busy(busy15),
        .done(done15), .pass(pass15), .err_cnt(err15)
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
        , .fail_valid(fv15), .fail_vec(fvec15)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d2, d0, d15, ndone;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy2}, 32'd0);
        chk("rst_done", {31'd0, done2}, 32'd0);
        chk("rst_pass", {31'd0, pass2}, 32'd0);
        chk("rst_err", {29'd0, err2}, 32'd0);
        chk("rst_ab", {30'd0, a2, b2}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // good OR cell on all three settle depths
        d2 = -1; d0 = -1; d15 = -1; ndone = 0;
        start = 1'b1;
        for (int k = 0; k < 75; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                chk("run1_busy", {31'd0, busy2}, 32'd1);
            end
            if (k == 0)  chk("seq_v0", {30'd0, a2, b2}, 32'd0);
            if (k == 4)  chk("seq_v1", {30'd0, a2, b2}, 32'd1);
            if (k == 8)  chk("seq_v2", {30'd0, a2, b2}, 32'd2);
            if (k == 12) chk("seq_v3", {30'd0, a2, b2}, 32'd3);
            if (k == 16) chk("seq_done", {30'd0, a2, b2}, 32'd0);
            if (done2) ndone++;
            if (done2 && d2 < 0) d2 = k;
            if (done0 && d0 < 0) d0 = k;
            if (done15 && d15 < 0) d15 = k;
        end
        chk("done_lat_s2", d2, 32'd16);
        chk("done_lat_s0", d0, 32'd8);
        chk("done_lat_s15", d15, 32'd68);
        chk("done_width", ndone, 32'd1);
        chk("run1_pass", {31'd0, pass2}, 32'd1);
        chk("run1_err", {29'd0, err2}, 32'd0);
        chk("run1_idle", {31'd0, busy2}, 32'd0);
        chk("s0_pass", {31'd0, pass0}, 32'd1);
        chk("s15_pass", {31'd0, pass15}, 32'd1);

        // cell stuck at 0: vectors 01,10,11 mismatch
        stuck0 = 1'b1;
        d2 = -1;
        start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (done2 && d2 < 0) d2 = k;
            if (k == 16) chk("stuck_pass_in_done", {31'd0, pass2}, 32'd0);
        end
        chk("stuck_done", d2, 32'd16);
        chk("stuck_err", {29'd0, err2}, 32'd3);
        chk("stuck_pass", {31'd0, pass2}, 32'd0);
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
        chk("stuck_fvalid", {31'd0, fv2}, 32'd1);
        chk("stuck_fvec", {30'd0, fvec2}, 32'd1);
`endif
        repeat (5) @(negedge clk);
        chk("idle_err_hold", {29'd0, err2}, 32'd3);

        // abort sampled at the 6th edge of the run
        stuck0 = 1'b0;
        ndone = 0;
        start = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 4) abort = 1'b1;
            if (k == 5) begin
                abort = 1'b0;
                chk("abort_busy", {31'd0, busy2}, 32'd0);
                chk("abort_pass", {31'd0, pass2}, 32'd0);
                chk("abort_ab", {30'd0, a2, b2}, 32'd0);
            end
            if (done2) ndone++;
        end
        chk("abort_nodone", ndone, 32'd0);

        // abort after one mismatch keeps the partial count
        stuck0 = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 8) abort = 1'b1;
            if (k == 9) begin
                abort = 1'b0;
                chk("abort2_busy", {31'd0, busy2}, 32'd0);
                chk("abort2_err", {29'd0, err2}, 32'd1);
            end
        end

        // asynchronous reset in WAIT of vector 10
        start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        chk("prerst_ab", {30'd0, a2, b2}, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy2}, 32'd0);
        chk("arst_err", {29'd0, err2}, 32'd0);
        chk("arst_ab", {30'd0, a2, b2}, 32'd0);
        chk("arst_done", {31'd0, done2}, 32'd0);
`ifdef GATE_SEQ_FAIL_CAPTURE_EN
        chk("arst_fvalid", {31'd0, fv2}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        stuck0 = 1'b0;
        repeat (70) @(negedge clk);
        d2 = -1;
        start = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (done2 && d2 < 0) d2 = k;
        end
        chk("postrst_done", d2, 32'd16);
        chk("postrst_pass", {31'd0, pass2}, 32'd1);

        // start held high; abort alongside start in IDLE must not block it
        ndone = 0;
        start = 1'b1;
        abort = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                abort = 1'b0;
                chk("startabort_busy", {31'd0, busy2}, 32'd1);
            end
            if (k == 4) chk("held_v1", {30'd0, a2, b2}, 32'd1);
            if (k < 17 && done2) ndone++;
            if (k == 17) chk("held_idle", {31'd0, busy2}, 32'd0);
            if (k == 18) chk("held_restart", {31'd0, busy2}, 32'd1);
        end
        chk("held_ndone", ndone, 32'd1);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("final_idle", {31'd0, busy2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_seq_ctrl.md
GATE_SEQ_CTRL -- requirements
Module: gate_seq_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning wait cycles between driving a vector and sampling the cell output (legal range 0-15).
REQ-002 SHALL have parameter TRUTH, default 4'b1110, meaning the expected 2-input truth table, where bit index is {a,b}; the default is OR.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin one exhaustive test run; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel the run in progress.
REQ-007 SHALL have port dut_out  input  1  output of the 2-input gate cell under test.
REQ-008 SHALL have port dut_a  output  1  a-input drive to the cell.
REQ-009 SHALL have port dut_b  output  1  b-input drive to the cell.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  single-cycle pulse at run completion.
REQ-012 SHALL have port pass  output  1  result of the last completed run.
REQ-013 SHALL have port err_cnt  output  3  mismatch count for the current or last run.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, WAIT, CHECK, DONE; all outputs registered.
REQ-015 SHALL move IDLE->APPLY when start=1 at a clock edge; on the same edge it SHALL clear err_cnt, clear pass, and set the vector counter to 0.
REQ-016 SHALL drive {dut_a,dut_b} = vector counter from APPLY through CHECK, and hold them at 2'b00 in IDLE and DONE.
REQ-017 SHALL go APPLY->WAIT, load the settle counter with SETTLE, and stay in WAIT until the counter reaches 0; with SETTLE=0 it SHALL go APPLY->CHECK directly.
REQ-018 SHALL, in CHECK, compare dut_out with TRUTH[vector] and increment err_cnt on mismatch; err_cnt max is 4, so no overflow is possible.
REQ-019 SHALL go CHECK->APPLY with vector+1 when vector<3, and CHECK->DONE when vector=3; the counter SHALL NOT wrap into a fifth vector.
REQ-020 SHALL assert done for exactly one cycle while in DONE, latch pass=(final err_cnt==0), then go DONE->IDLE.
REQ-021 SHALL assert done 4*(SETTLE+2)+1 clocks after the edge that samples start; with SETTLE=2 this is 17 clocks.
REQ-022 SHALL ignore start while busy=1.
REQ-023 SHALL, when abort=1 in any busy state, enter IDLE on the next edge with done=0 and pass=0, and leave err_cnt holding the partial count.
REQ-024 SHALL give abort priority over all other transitions; abort in IDLE SHALL have no effect.
REQ-025 SHALL, when start and abort are both high in IDLE, start the run; abort is evaluated only from APPLY onward.
REQ-026 SHALL hold pass and err_cnt stable in IDLE until the next accepted start.

Reset
REQ-027 SHALL, when rst=1 asynchronously, force IDLE and set dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_cnt=0, and clear the vector and settle counters.
REQ-028 SHALL, on rst mid-run, discard the run with no done pulse, and SHALL accept the first start after rst deasserts.

Configuration
REQ-029 SHALL support macro GATE_SEQ_FAIL_CAPTURE_EN.
REQ-030 SHALL, when the macro is defined, add output fail_valid (1 bit) and output fail_vec (2 bits). fail_vec captures the vector of the first mismatch in a run and fail_valid is set at that capture. Both SHALL clear on accepted start and on rst, and stay stable after DONE.
REQ-031 SHALL, when the macro is undefined, omit both ports and all related logic; all other behaviour SHALL be identical.

Verification
REQ-032 SHALL cover: good OR cell, SETTLE=2, start pulse -> done at clock 17, pass=1, err_cnt=0, and {dut_a,dut_b} sequence 00,01,10,11.
REQ-033 SHALL cover: dut_out tied to 0 -> err_cnt=3, pass=0; with macro defined, fail_vec=2'b01 and fail_valid=1.
REQ-034 SHALL cover: SETTLE=0 -> done at clock 9; SETTLE=15 -> done at clock 69.
REQ-035 SHALL cover: abort asserted at clock 6 -> IDLE at clock 7, no done pulse, pass=0, busy=0.
REQ-036 SHALL cover: rst pulsed mid-WAIT -> all outputs 0 immediately (asynchronously); next start completes a normal run.
REQ-037 SHALL cover: start held high throughout a run -> extra starts ignored while busy; a new run begins the cycle after DONE returns to IDLE.
